pio_edge_in: RTL and testbench
==============================

PIO_EDGE_IN -- requirements
Module: pio_edge_in

Interface
REQ-001 The block SHALL have these parameters:
- WIDTH, default 8, number of input bits (1..32).
- SYNC_STAGES, default 2, synchroniser flops per bit (2..4).
- DEB_W, default 16, debounce counter width (1..32).
- DEB_RESET, default 0, reset value of the debounce limit.
- IRQ_MASK_RESET, default 0, reset value of irq_mask.
REQ-002 The block SHALL have these ports:
- clk  in  1  single clock; all state on its rising edge.
- reset_n  in  1  asynchronous active-low reset.
- address  in  3  register select.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe.
- writedata  in  32  write data.
- in_port  in  WIDTH  asynchronous external inputs.
- readdata  out  32  registered read data.
- irq  out  1  active-high interrupt.
REQ-003 The block SHALL use one clock and an asynchronous, active-low reset.

Function
REQ-004 The register map SHALL be:
- 0 data (stable), RO.
- 1 rise_en, RW.
- 2 irq_mask, RW.
- 3 edge_capture, RW1C.
- 4 fall_en, RW.
- 5 deb_limit (DEB_W bits), RW.
- 6 raw synchronised input, RO.
- 7 status (bit0 = irq), RO.
REQ-005 A write SHALL occur on a clock edge where chipselect=1 and write_n=0; writes to RO addresses SHALL be ignored; writedata bits above a register's width SHALL be ignored.
REQ-006 readdata SHALL register the selected register every clock regardless of chipselect, so it is valid one cycle after address; unused upper bits SHALL read 0.
REQ-007 Each in_port bit SHALL pass through SYNC_STAGES flops; the last stage is "synced".
REQ-008 Per bit, a DEB_W-bit counter SHALL track "synced != stable":
- while mismatched and cnt < deb_limit, cnt increments;
- when mismatched and cnt >= deb_limit, stable <= synced and cnt <= 0;
- when matched, cnt <= 0.
REQ-009 As a result, stable SHALL change only after a mismatch sampled on deb_limit+1 consecutive edges; deb_limit=0 SHALL make stable follow synced with one cycle delay.
REQ-010 Because of the >= compare, writing deb_limit below a running count SHALL cause the update on the next mismatched edge; the counter SHALL never wrap.
REQ-011 stable_d SHALL register stable each cycle. Per bit, an edge event SHALL be (stable & ~stable_d & rise_en) | (~stable & stable_d & fall_en).
REQ-012 edge_capture bit SHALL set on the edge following the cycle in which its event is true and SHALL hold until cleared.
REQ-013 A write to address 3 SHALL clear each edge_capture bit whose writedata bit is 1; bits written 0 SHALL be unchanged.
REQ-014 If an edge event and a W1C clear hit the same bit on the same edge, set SHALL win.
REQ-015 irq SHALL equal |(edge_capture & irq_mask), decoded from registers only, with no combinational path from bus inputs.
REQ-016 Changing rise_en/fall_en SHALL NOT alter already-captured bits; changing irq_mask SHALL affect irq on the following cycle.

Reset
REQ-017 On reset_n=0, asynchronously:
- sync flops, stable, stable_d, counters, edge_capture, readdata SHALL go to 0;
- rise_en SHALL go to all ones and fall_en to 0;
- irq_mask SHALL go to IRQ_MASK_RESET and deb_limit to DEB_RESET;
- irq SHALL be 0 unless implied by these values (it is 0 for defaults).
REQ-018 An input held at 1 through reset release SHALL register as a rising edge once it reaches stable; this is required behaviour.
REQ-019 Reset asserted mid-debounce or mid-capture SHALL discard all in-progress state with no partial update after release.

Verification
REQ-020 Defaults, deb_limit=0, mask=0xFF, in_port 0x00->0x01: edge_capture=0x01 and irq=1 exactly SYNC_STAGES+2 edges after the change; reading address 0 returns 0x01.
REQ-021 fall_en=0x02, rise_en=0x00, bit1 1->0: capture=0x02; a subsequent bit1 0->1 does not set capture.
REQ-022 deb_limit=3, 2-cycle glitch on bit2: no stable or capture change; a 4-cycle pulse updates stable on the 4th mismatched edge.
REQ-023 capture=0x05, write 0x04 to address 3: capture=0x01; a new bit2 event on the same edge as the write leaves capture=0x05.
REQ-024 Assert reset_n mid-debounce with capture=0xFF: all registers hit reset values immediately; irq=0; readdata=0.

Source files
------------

// File: rtl/pio_edge_in.sv
`default_nettype none
// ----------------------------------------------------------------------------
// pio_edge_in : synchronised, debounced parallel input port with edge capture
//               and maskable interrupt behind a small register slave.
// Revision    : 1.0
// ----------------------------------------------------------------------------
module pio_edge_in #(
  parameter int          WIDTH          = 8,
  parameter int          SYNC_STAGES    = 2,
  parameter int          DEB_W          = 16,
  parameter logic [31:0] DEB_RESET      = 32'd0,
  parameter logic [31:0] IRQ_MASK_RESET = 32'd0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  localparam logic [DEB_W-1:0] C_DEB_RESET  = DEB_RESET[DEB_W-1:0];
  localparam logic [WIDTH-1:0] C_MASK_RESET = IRQ_MASK_RESET[WIDTH-1:0];

  localparam logic [2:0] C_ADDR_DATA   = 3'd0;
  localparam logic [2:0] C_ADDR_RISE   = 3'd1;
  localparam logic [2:0] C_ADDR_MASK   = 3'd2;
  localparam logic [2:0] C_ADDR_CAP    = 3'd3;
  localparam logic [2:0] C_ADDR_FALL   = 3'd4;
  localparam logic [2:0] C_ADDR_DEB    = 3'd5;
  localparam logic [2:0] C_ADDR_RAW    = 3'd6;
  localparam logic [2:0] C_ADDR_STATUS = 3'd7;

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] w_synced;
  logic [WIDTH-1:0] stable_q, stable_d, stable_dly_q;
  logic [WIDTH-1:0] rise_en_q, fall_en_q, irq_mask_q;
  logic [WIDTH-1:0] edge_cap_q, edge_cap_d;
  logic [WIDTH-1:0] w_event;
  logic [DEB_W-1:0] deb_limit_q;
  logic [31:0]      readdata_q, readdata_d;
  logic             w_wr;
  logic             w_unused_wdata;

  assign w_wr           = chipselect && !write_n;
  assign w_synced       = sync_q[SYNC_STAGES-1];
  assign w_unused_wdata = ^writedata;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        sync_q[s] <= '0;
      end
    end else begin
      sync_q[0] <= in_port;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        sync_q[s] <= sync_q[s-1];
      end
    end
  end

  // Per-bit debounce: the >= compare lets a lowered limit take effect at once
  // and keeps the counter from ever wrapping.
  for (genvar b = 0; b < WIDTH; b++) begin : g_deb
    logic [DEB_W-1:0] cnt_q, cnt_d;
    logic             w_mismatch, w_expire;

    assign w_mismatch  = w_synced[b] ^ stable_q[b];
    assign w_expire    = w_mismatch && (cnt_q >= deb_limit_q);
    assign stable_d[b] = w_expire ? w_synced[b] : stable_q[b];

    always_comb begin
      cnt_d = '0;
      if (w_mismatch && !w_expire) begin
        cnt_d = cnt_q + DEB_W'(1);
      end
    end

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_d;
      end
    end
  end

  assign w_event = (stable_q & ~stable_dly_q & rise_en_q)
                 | (~stable_q & stable_dly_q & fall_en_q);

  // A new event overrides a simultaneous W1C clear of the same bit.
  always_comb begin
    edge_cap_d = edge_cap_q;
    if (w_wr && (address == C_ADDR_CAP)) begin
      edge_cap_d = edge_cap_q & ~writedata[WIDTH-1:0];
    end
    edge_cap_d = edge_cap_d | w_event;
  end

  assign irq = |(edge_cap_q & irq_mask_q);

  always_comb begin
    readdata_d = '0;
    case (address)
      C_ADDR_DATA:   readdata_d = 32'(stable_q);
      C_ADDR_RISE:   readdata_d = 32'(rise_en_q);
      C_ADDR_MASK:   readdata_d = 32'(irq_mask_q);
      C_ADDR_CAP:    readdata_d = 32'(edge_cap_q);
      C_ADDR_FALL:   readdata_d = 32'(fall_en_q);
      C_ADDR_DEB:    readdata_d = 32'(deb_limit_q);
      C_ADDR_RAW:    readdata_d = 32'(w_synced);
      C_ADDR_STATUS: readdata_d = {31'd0, irq};
      default:       readdata_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stable_q     <= '0;
      stable_dly_q <= '0;
      rise_en_q    <= '1;
      fall_en_q    <= '0;
      irq_mask_q   <= C_MASK_RESET;
      deb_limit_q  <= C_DEB_RESET;
      edge_cap_q   <= '0;
      readdata_q   <= '0;
    end else begin
      stable_q     <= stable_d;
      stable_dly_q <= stable_q;
      edge_cap_q   <= edge_cap_d;
      readdata_q   <= readdata_d;
      if (w_wr) begin
        case (address)
          C_ADDR_RISE: rise_en_q   <= writedata[WIDTH-1:0];
          C_ADDR_MASK: irq_mask_q  <= writedata[WIDTH-1:0];
          C_ADDR_FALL: fall_en_q   <= writedata[WIDTH-1:0];
          C_ADDR_DEB:  deb_limit_q <= writedata[DEB_W-1:0];
          default: ;
        endcase
      end
    end
  end

  assign readdata = readdata_q;

endmodule
`default_nettype wire

// File: tb/tb_pio_edge_in.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_pio_edge_in : register table, directed corner sequences and random bus /
//                  input traffic compared against a behavioural model.
// Revision       : 1.0
// ----------------------------------------------------------------------------
module tb_pio_edge_in;

  localparam int SYNC = 2;

  logic        clk;
  logic        reset_n;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [7:0]  in_port;
  logic [31:0] readdata;
  logic        irq;

  int vectors;
  int miscompares;

  pio_edge_in #(
    .WIDTH(8), .SYNC_STAGES(SYNC), .DEB_W(16),
    .DEB_RESET(32'd0), .IRQ_MASK_RESET(32'd0)
  ) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .readdata(readdata), .irq(irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural reference: an input value is visible SYNC edges after it is
  // sampled; a bit's debounced value flips once the mismatch has been seen on
  // limit+1 consecutive edges.
  bit [7:0]    m_sync [SYNC];
  bit [7:0]    m_stable, m_prev, m_rise, m_fall, m_mask, m_cap;
  int unsigned m_lim;
  int unsigned m_run [8];
  bit [31:0]   m_rd;

  function automatic bit m_irq();
    return |(m_cap & m_mask);
  endfunction

  function automatic void model_reset();
    for (int s = 0; s < SYNC; s++) m_sync[s] = 8'h00;
    for (int b = 0; b < 8; b++) m_run[b] = 0;
    m_stable = 8'h00; m_prev = 8'h00; m_rise = 8'hFF; m_fall = 8'h00;
    m_mask = 8'h00; m_cap = 8'h00; m_lim = 0; m_rd = 32'h0;
  endfunction

  function automatic void model_edge(input bit [2:0] a, input bit cs, input bit wn,
                                     input bit [31:0] wd, input bit [7:0] inp);
    bit [7:0]  seen, nxt, rises, falls, cap;
    bit [31:0] rd;
    bit        we;
    seen = m_sync[SYNC-1];
    we   = cs && !wn;
    case (a)
      3'd0: rd = {24'h0, m_stable};
      3'd1: rd = {24'h0, m_rise};
      3'd2: rd = {24'h0, m_mask};
      3'd3: rd = {24'h0, m_cap};
      3'd4: rd = {24'h0, m_fall};
      3'd5: rd = m_lim;
      3'd6: rd = {24'h0, seen};
      default: rd = {31'h0, m_irq()};
    endcase
    rises = m_stable & ~m_prev;
    falls = m_prev & ~m_stable;
    nxt = m_stable;
    for (int b = 0; b < 8; b++) begin
      if (seen[b] == m_stable[b]) m_run[b] = 0;
      else if (m_run[b] + 1 > m_lim) begin nxt[b] = seen[b]; m_run[b] = 0; end
      else m_run[b] = m_run[b] + 1;
    end
    cap = m_cap;
    if (we && a == 3'd3) cap = cap & ~wd[7:0];
    cap = cap | (rises & m_rise) | (falls & m_fall);
    if (we) begin
      if (a == 3'd1) m_rise = wd[7:0];
      if (a == 3'd2) m_mask = wd[7:0];
      if (a == 3'd4) m_fall = wd[7:0];
      if (a == 3'd5) m_lim  = wd[15:0];
    end
    for (int s = SYNC - 1; s > 0; s--) m_sync[s] = m_sync[s-1];
    m_sync[0] = inp;
    m_prev = m_stable; m_stable = nxt; m_cap = cap; m_rd = rd;
  endfunction

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge(address, chipselect, write_n, writedata, in_port);
    #1;
    cmp("model_readdata", readdata, m_rd);
    cmp("model_irq", {31'h0, irq}, {31'h0, m_irq()});
  endtask

  task automatic wr(input bit [2:0] a, input bit [31:0] d);
    address = a; chipselect = 1'b1; write_n = 1'b0; writedata = d;
    tick();
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic rd_check(input bit [2:0] a, input bit [31:0] exp, input string name);
    address = a;
    tick();
    cmp(name, readdata, exp);
  endtask

  typedef struct {
    bit [2:0]  a;
    bit [31:0] wd;
    bit [31:0] exp;
  } reg_vec_t;

  reg_vec_t tbl [8];

  initial begin
    tbl[0] = '{3'd1, 32'h0000_01A5, 32'h0000_00A5};
    tbl[1] = '{3'd2, 32'hFFFF_FF5A, 32'h0000_005A};
    tbl[2] = '{3'd4, 32'h0000_0F3C, 32'h0000_003C};
    tbl[3] = '{3'd5, 32'h0012_3456, 32'h0000_3456};
    tbl[4] = '{3'd0, 32'hFFFF_FFFF, 32'h0000_0000};
    tbl[5] = '{3'd6, 32'hFFFF_FFFF, 32'h0000_0000};
    tbl[6] = '{3'd7, 32'hFFFF_FFFF, 32'h0000_0000};
    tbl[7] = '{3'd3, 32'hFFFF_FFFF, 32'h0000_0000};

    vectors = 0; miscompares = 0;
    model_reset();
    reset_n = 1'b0; address = 3'd0; chipselect = 1'b0; write_n = 1'b1;
    writedata = 32'h0; in_port = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    cmp("reset_readdata", readdata, 32'h0);
    cmp("reset_irq", {31'h0, irq}, 32'h0);
    @(negedge clk) reset_n = 1'b1;

    rd_check(3'd1, 32'hFF, "reset_rise_en");
    rd_check(3'd4, 32'h00, "reset_fall_en");
    rd_check(3'd5, 32'h00, "reset_deb_limit");

    for (int i = 0; i < 8; i++) begin
      wr(tbl[i].a, tbl[i].wd);
      rd_check(tbl[i].a, tbl[i].exp, $sformatf("regtbl%0d", i));
    end
    wr(3'd1, 32'hFF); wr(3'd2, 32'h00); wr(3'd4, 32'h00); wr(3'd5, 32'h00);

    // Rising edge with limit 0 reaches capture/irq SYNC+2 edges after change
    wr(3'd2, 32'hFF);
    address = 3'd3;
    in_port = 8'h01;
    for (int k = 1; k <= SYNC + 2; k++) begin
      tick();
      cmp($sformatf("rise_latency_irq_e%0d", k), {31'h0, irq}, {31'h0, (k == SYNC + 2)});
    end
    rd_check(3'd3, 32'h01, "rise_capture");
    rd_check(3'd0, 32'h01, "rise_data");
    rd_check(3'd7, 32'h01, "rise_status");
    wr(3'd3, 32'hFF);
    cmp("w1c_irq_clear", {31'h0, irq}, 32'h0);

    // Falling-only enable on bit 1
    wr(3'd1, 32'h00); wr(3'd4, 32'h02);
    in_port = 8'h03; repeat (6) tick();
    in_port = 8'h01; repeat (6) tick();
    rd_check(3'd3, 32'h02, "fall_capture");
    in_port = 8'h03; repeat (6) tick();
    rd_check(3'd3, 32'h02, "fall_no_rise");
    wr(3'd3, 32'hFF);

    // Debounce limit 3: 2-cycle glitch rejected, 4-cycle pulse accepted
    wr(3'd4, 32'h00); wr(3'd1, 32'h04); wr(3'd5, 32'h03);
    in_port = 8'h07; tick(); tick();
    in_port = 8'h03; repeat (8) tick();
    rd_check(3'd0, 32'h03, "glitch_data");
    rd_check(3'd3, 32'h00, "glitch_capture");
    address = 3'd0;
    in_port = 8'h07;
    for (int k = 1; k <= 7; k++) begin
      tick();
      if (k == 4) in_port = 8'h03;
      if (k == 6) cmp("pulse_data_before", readdata, 32'h03);
      if (k == 7) cmp("pulse_data_after", readdata, 32'h07);
    end
    repeat (8) tick();
    rd_check(3'd3, 32'h04, "pulse_capture");

    // W1C partial clear and set-wins-over-clear on the same edge
    wr(3'd5, 32'h00); wr(3'd1, 32'hFF); wr(3'd3, 32'hFF);
    in_port = 8'h00; repeat (6) tick();
    wr(3'd3, 32'hFF);
    in_port = 8'h05; repeat (6) tick();
    rd_check(3'd3, 32'h05, "cap_05");
    wr(3'd3, 32'h04);
    rd_check(3'd3, 32'h01, "w1c_partial");
    in_port = 8'h01; repeat (6) tick();
    in_port = 8'h05; repeat (SYNC + 1) tick();
    wr(3'd3, 32'h04);
    rd_check(3'd3, 32'h05, "set_wins");

    // Async reset mid-debounce with full capture
    wr(3'd4, 32'hFF); wr(3'd2, 32'hFF);
    in_port = 8'h00; repeat (6) tick();
    in_port = 8'hFF; repeat (6) tick();
    rd_check(3'd3, 32'hFF, "cap_ff");
    cmp("cap_ff_irq", {31'h0, irq}, 32'h1);
    wr(3'd5, 32'h05);
    in_port = 8'h00; repeat (4) tick();
    #3 reset_n = 1'b0;
    #1;
    cmp("async_reset_readdata", readdata, 32'h0);
    cmp("async_reset_irq", {31'h0, irq}, 32'h0);
    model_reset();
    in_port = 8'h01;
    repeat (2) @(posedge clk);
    #1;
    cmp("in_reset_readdata", readdata, 32'h0);
    @(negedge clk) reset_n = 1'b1;
    repeat (SYNC + 3) tick();
    rd_check(3'd3, 32'h01, "held_high_rise");
    rd_check(3'd1, 32'hFF, "post_reset_rise_en");
    rd_check(3'd4, 32'h00, "post_reset_fall_en");
    rd_check(3'd5, 32'h00, "post_reset_deb");
    rd_check(3'd7, 32'h00, "post_reset_status");

    // Random bus and input traffic against the model
    for (int n = 0; n < 600; n++) begin
      address    = 3'($urandom_range(0, 7));
      chipselect = 1'($urandom_range(0, 1));
      write_n    = 1'($urandom_range(0, 1));
      writedata  = $urandom;
      if (address == 3'd5) writedata = $urandom_range(0, 3);
      if ($urandom_range(0, 3) == 0) in_port = 8'($urandom);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
